// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds operand bits LSB first to an external
// full_adder and assembles the sum, carry-out and signed overflow.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_A,
  output logic             fa_B,
  output logic             fa_C,
  input  logic             fa_F,
  input  logic             fa_Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is a request sampled on a rising edge; it is accepted
  // only in IDLE or DONE (busy=0), and done pulses one cycle per result.

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             a_bit;
  logic             b_bit;

  assign state_dbg = state;

  // Bit select and partial-sum capture via compare loop keeps index widths exact.
  always_comb begin
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    psum_next = psum;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) begin
        a_bit        = a_q[i];
        b_bit        = b_q[i];
        psum_next[i] = fa_F;
      end
    end
  end

  assign fa_A = (state == RUN) & a_bit;
  assign fa_B = (state == RUN) & b_bit;
  assign fa_C = (state == RUN) & carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      psum    <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          psum    <= psum_next;
          carry_q <= fa_Ci;
          if (cnt == LAST) begin
            // cnt holds at its last value rather than wrapping.
            sum   <= psum_next;
            cout  <= fa_Ci;
            ovf   <= carry_q ^ fa_Ci;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
            psum    <= '0;
            state   <= RUN;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         fa_A, fa_B, fa_C, fa_F, fa_Ci;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .fa_A(fa_A), .fa_B(fa_B), .fa_C(fa_C), .fa_F(fa_F), .fa_Ci(fa_Ci),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  assign fa_F  = fa_A ^ fa_B ^ fa_C;
  assign fa_Ci = (fa_A & fa_B) | (fa_A & fa_C) | (fa_B & fa_C);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called just after the start-accepting edge; operands are scrambled while
  // running and must not matter.
  task automatic wait_result(input string tag, input logic [W-1:0] es,
                             input logic ec, input logic eo);
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_done_early"}, done, 1'b0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    logic [W-1:0] av, bv;
    logic         c;
    int           pulses;

    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    chk("rst_fa", {fa_A, fa_B, fa_C}, 3'b000);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);

    launch(8'h0F, 8'h01, 1'b0);
    wait_result("s1", 8'h10, 1'b0, 1'b0);
    tick();
    chk("s1_done_pulse", done, 1'b0);
    chk("s1_hold_sum", sum, 8'h10);
    chk("s1_idle", state_dbg, 2'd0);

    launch(8'hFF, 8'h01, 1'b0);
    wait_result("s2", 8'h00, 1'b1, 1'b0);
    tick();

    // Second start issued in the DONE cycle: next done 9 cycles after first.
    launch(8'h7F, 8'h01, 1'b0);
    wait_result("s3a", 8'h80, 1'b0, 1'b1);
    launch(8'hFF, 8'hFF, 1'b1);
    wait_result("s3b", 8'hFF, 1'b1, 1'b0);
    tick();
    chk("s3b_done_pulse", done, 1'b0);

    // Start re-pulsed in RUN cycle 3 must be ignored.
    launch(8'h12, 8'h34, 1'b0);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 9) begin
        chk("s4_sum", sum, 8'h46);
        chk("s4_cout", cout, 1'b0);
        chk("s4_ovf", ovf, 1'b0);
        chk("s4_done_at9", done, 1'b1);
      end
      if (done) pulses++;
      tick();
    end
    start = 1'b0;
    chk("s4_one_pulse", pulses, 1);

    // Reset in RUN cycle 4 aborts.
    launch(8'h55, 8'h22, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_busy", busy, 1'b0);
    chk("s5_sum", sum, 8'h00);
    chk("s5_cout", cout, 1'b0);
    chk("s5_done", done, 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      tick();
    end
    chk("s5_no_pulse", pulses, 0);
    launch(8'h55, 8'h22, 1'b0);
    wait_result("s5r", 8'h77, 1'b0, 1'b0);
    tick();

    // Full-adder pins: LSB first, carry follows a reference ripple.
    chk("s6_fa_idle", {fa_A, fa_B, fa_C}, 3'b000);
    av = 8'hA5; bv = 8'h3C; c = 1'b0;
    launch(av, bv, c);
    for (int i = 0; i < W; i++) begin
      chk("s6_fa_A", fa_A, av[i]);
      chk("s6_fa_B", fa_B, bv[i]);
      chk("s6_fa_C", fa_C, c);
      c = (av[i] & bv[i]) | (av[i] & c) | (bv[i] & c);
      tick();
    end
    chk("s6_done", done, 1'b1);
    chk("s6_fa_done", {fa_A, fa_B, fa_C}, 3'b000);
    chk("s6_sum", sum, 8'hE1);
    chk("s6_cout", cout, 1'b0);
    tick();
    chk("s6_fa_after", {fa_A, fa_B, fa_C}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition.
REQ-005 The block SHALL have ports a and b, each input, WIDTH bits: operands, sampled only when start is accepted.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, sampled with a and b.
REQ-007 The block SHALL have ports fa_A, fa_B and fa_C, each output, 1 bit: operand bits and carry driven to the external full_adder A, B and C pins.
REQ-008 The block SHALL have ports fa_F and fa_Ci, each input, 1 bit: sum and carry returned from the full_adder F and Ci pins.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result register.
REQ-012 The block SHALL have port cout, output, 1 bit: final carry-out register.
REQ-013 The block SHALL have port ovf, output, 1 bit: signed overflow register (carry into MSB XOR carry out of MSB).

Function
REQ-014 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-015 IDLE to RUN SHALL occur on an edge where start=1; at that edge the block SHALL latch a, b and cin into internal registers and clear the bit counter to 0.
REQ-016 In RUN, fa_A and fa_B SHALL equal latched bit [cnt] of a and b (LSB first), and fa_C SHALL equal the carry register; the carry register SHALL initially hold the latched cin.
REQ-017 At each RUN edge the block SHALL store fa_F into partial-sum bit [cnt], load fa_Ci into the carry register and increment cnt.
REQ-018 When cnt = WIDTH-1 at a RUN edge, after the capture in REQ-017: sum SHALL load the full partial sum, cout SHALL load fa_Ci, ovf SHALL load fa_C XOR fa_Ci, and the state SHALL go to DONE.
REQ-019 Latency: done SHALL be high exactly in the cycle following the WIDTH-th edge after the start-accepting edge, and low in every other cycle.
REQ-020 DONE SHALL last one cycle: start=1 in DONE SHALL be accepted as in REQ-015 (back-to-back operation); otherwise the state SHALL go to IDLE.
REQ-021 busy SHALL be 1 in RUN only, and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored while in RUN; latched operands SHALL not change.
REQ-023 Changes on a, b or cin after acceptance SHALL not affect the result.
REQ-024 fa_A, fa_B and fa_C SHALL be 0 in IDLE and DONE.
REQ-025 sum, cout and ovf SHALL change only at the edge entering DONE, and SHALL hold until the next such edge.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, SHALL never exceed WIDTH-1 in RUN, and SHALL not wrap.
REQ-027 For WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-028 With rst=1 at an edge, the block SHALL enter IDLE and clear cnt, the carry register, latched operands, the partial sum, sum, cout, ovf, busy and done to 0; rst SHALL take priority over start.
REQ-029 Reset during RUN SHALL abort the operation: no done pulse and results reading 0; a new start SHALL be accepted on the first edge after rst deasserts.

Verification (WIDTH=8, behavioural full_adder attached)
REQ-030 Scenario: a=0x0F, b=0x01, cin=0, start for 1 cycle -> busy high for 8 cycles, then done pulse; sum=0x10, cout=0, ovf=0.
REQ-031 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-032 Scenario: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; then a=0xFF, b=0xFF, cin=1 started in the DONE cycle -> next done pulse exactly 9 cycles after the first, with sum=0xFF, cout=1, ovf=0.
REQ-033 Scenario: start pulsed again in RUN cycle 3 with different operands -> ignored; result matches the first operands; exactly one done pulse.
REQ-034 Scenario: rst asserted in RUN cycle 4 -> following cycle shows busy=0, sum=0x00, cout=0 and no done pulse; a restart gives the correct result.
REQ-035 Scenario: fa_A, fa_B and fa_C monitored across a=0xA5, b=0x3C -> bits presented LSB first, one per cycle, and all 0 outside RUN.
